sprite_renderer_param: RTL and testbench

Parametrised scanline sprite renderer for the tank/playfield video pipeline. It replaces the fixed 16x16 renderer and sits between a tank controller (vstart/hstart/load strobes, rotation-derived mirror bits) and a bitmap ROM. Sprite width, height and ROM word width are generic. It adds 2x horizontal and vertical scaling, per-sprite latching of mode bits, and line/frame completion strobes.

---
 rtl/sprite_pkg.sv | 39 +++
 rtl/sprite_line_buf.sv | 41 ++++
 rtl/sprite_renderer_param.sv | 156 +++++++++++++++
 tb/tb_sprite_renderer_param.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the parametrised scanline sprite renderer.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOAD,
    SETUP,
    CAPTURE,
    WAIT_HSTART,
    DRAW
  } state_e;

  // Mode bits captured once per sprite when vstart is accepted.
  typedef struct packed {
    logic hmirror;
    logic vmirror;
    logic xscale;
    logic yscale;
  } mode_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Geometry of the classic 16x16 sprite fed by an 8-bit ROM.
  localparam int DEF_W      = 16;
  localparam int DEF_H      = 16;
  localparam int DEF_ROM_DW = 8;
  localparam int NW         = DEF_W / DEF_ROM_DW;
  localparam int AW_ROW     = clog2(DEF_H);
  localparam int AW_WORD    = clog2(NW);

endpackage

// File: rtl/sprite_line_buf.sv
// One scanline of sprite bitmap: word-wide write port, single-pixel read port.
module sprite_line_buf
  import sprite_pkg::*;
#(
  parameter  int W      = 16,
  parameter  int ROM_DW = 8,
  localparam int WIW    = (clog2(W / ROM_DW) > 0) ? clog2(W / ROM_DW) : 1,
  localparam int PW     = clog2(W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [WIW-1:0]    wi_i,
  input  logic [ROM_DW-1:0] data_i,
  input  logic [PW-1:0]     p_i,
  input  logic              hmirror_i,
  output logic              pix_o
);

  logic [W-1:0]  line_q;
  logic [PW-1:0] base;
  logic [PW-1:0] idx;

  // Word offset inside the line; bit 0 is the leftmost unmirrored pixel.
  always_comb begin
    base = PW'(wi_i) * PW'(ROM_DW);
  end

  // Capture one ROM word per fetch cycle into its slot of the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) line_q <= '0;
    else if (we_i) line_q[base +: ROM_DW] <= data_i;
  end

  // Pixel select, reversing the line when horizontally mirrored.
  always_comb begin
    idx   = hmirror_i ? (PW'(W - 1) - p_i) : p_i;
    pix_o = line_q[idx];
  end

endmodule

// File: rtl/sprite_renderer_param.sv
// Scanline sprite renderer: fetches one bitmap row per line, then shifts it out.
module sprite_renderer_param
  import sprite_pkg::*;
#(
  parameter  int W      = 16,
  parameter  int H      = 16,
  parameter  int ROM_DW = 8,
  localparam int AW     = clog2(H) + clog2(W / ROM_DW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vstart_i,
  input  logic              load_i,
  input  logic              hstart_i,
  input  logic              hmirror_i,
  input  logic              vmirror_i,
  input  logic              xscale_i,
  input  logic              yscale_i,
  output logic [AW-1:0]     rom_addr_o,
  input  logic [ROM_DW-1:0] rom_bits_i,
  output logic              gfx_o,
  output logic              busy_o,
  output logic              line_done_o,
  output logic              frame_done_o
);

  localparam int NWL = W / ROM_DW;
  localparam int AWR = clog2(H);
  localparam int AWW = clog2(NWL);
  localparam int WIW = (AWW > 0) ? AWW : 1;
  localparam int XCW = clog2(W) + 1;
  localparam int LCW = AWR + 1;
  localparam int PW  = clog2(W);

  state_e         state_q;
  mode_t          mode_q;
  logic [WIW-1:0] wi_q;
  logic [XCW-1:0] xc_q;
  logic [LCW-1:0] lc_q;
  logic [AW-1:0]  romAddr_q;
  logic           gfx_q;
  logic           lineDone_q;
  logic           frameDone_q;

  logic [AWR-1:0] rowRaw;
  logic [AWR-1:0] row;
  logic [AW-1:0]  romAddr_d;
  logic [PW-1:0]  pixIdx;
  logic [XCW-1:0] xcLast;
  logic [LCW-1:0] lcLast;
  logic           wiLast;
  logic           pix;
  logic           lineWe;

  // Row/pixel addressing derived from the counters and the latched mode.
  always_comb begin
    rowRaw    = AWR'(mode_q.yscale ? (lc_q >> 1) : lc_q);
    row       = mode_q.vmirror ? (AWR'(H - 1) - rowRaw) : rowRaw;
    romAddr_d = (AW'(row) << AWW) | AW'(wi_q);
    pixIdx    = PW'(mode_q.xscale ? (xc_q >> 1) : xc_q);
    xcLast    = mode_q.xscale ? XCW'(2 * W - 1) : XCW'(W - 1);
    lcLast    = mode_q.yscale ? LCW'(2 * H - 1) : LCW'(H - 1);
    wiLast    = (wi_q == WIW'(NWL - 1));
    lineWe    = (state_q == CAPTURE);
  end

  sprite_line_buf #(
    .W      (W),
    .ROM_DW (ROM_DW)
  ) u_line (
    .clk       (clk),
    .reset     (reset),
    .we_i      (lineWe),
    .wi_i      (wi_q),
    .data_i    (rom_bits_i),
    .p_i       (pixIdx),
    .hmirror_i (mode_q.hmirror),
    .pix_o     (pix)
  );

  // Sprite sequencer: mode latch, row fetch, pixel drawing and completion strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      wi_q        <= '0;
      xc_q        <= '0;
      lc_q        <= '0;
      romAddr_q   <= '0;
      gfx_q       <= 1'b0;
      lineDone_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      lineDone_q  <= 1'b0;
      frameDone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          lc_q  <= '0;
          gfx_q <= 1'b0;
          if (vstart_i) begin
            mode_q.hmirror <= hmirror_i;
            mode_q.vmirror <= vmirror_i;
            mode_q.xscale  <= xscale_i;
            mode_q.yscale  <= yscale_i;
            state_q        <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          wi_q  <= '0;
          xc_q  <= '0;
          gfx_q <= 1'b0;
          if (load_i) state_q <= SETUP;
        end
        SETUP: begin
          romAddr_q <= romAddr_d;
          state_q   <= CAPTURE;
        end
        CAPTURE: begin
          if (wiLast) begin
            state_q <= WAIT_HSTART;
          end else begin
            wi_q    <= wi_q + WIW'(1);
            state_q <= SETUP;
          end
        end
        WAIT_HSTART: begin
          if (hstart_i) state_q <= DRAW;
        end
        DRAW: begin
          gfx_q <= pix;
          if (xc_q == xcLast) begin
            lineDone_q <= 1'b1;
            lc_q       <= lc_q + LCW'(1);
            xc_q       <= '0;
            if (lc_q == lcLast) begin
              frameDone_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              state_q <= WAIT_LOAD;
            end
          end else begin
            xc_q <= xc_q + XCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr_o   = romAddr_q;
  assign gfx_o        = gfx_q;
  assign busy_o       = (state_q != IDLE);
  assign line_done_o  = lineDone_q;
  assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_sprite_renderer_param.sv
// Directed bench for sprite_renderer_param across three geometries.
module tb_sprite_renderer_param;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Instance A: 16x16 sprite, 8-bit ROM, row r holds a single set bit r.
  logic       vstartA, loadA, hstartA, hmA, vmA, xsA, ysA;
  logic [4:0] romAddrA;
  logic [7:0] romBitsA;
  logic       gfxA, busyA, ldA, fdA;
  logic [15:0] romRowA;

  assign romRowA  = 16'h0001 << romAddrA[4:1];
  assign romBitsA = romAddrA[0] ? romRowA[15:8] : romRowA[7:0];

  sprite_renderer_param #(.W(16), .H(16), .ROM_DW(8)) dutA (
    .clk(clk), .reset(reset), .vstart_i(vstartA), .load_i(loadA), .hstart_i(hstartA),
    .hmirror_i(hmA), .vmirror_i(vmA), .xscale_i(xsA), .yscale_i(ysA),
    .rom_addr_o(romAddrA), .rom_bits_i(romBitsA), .gfx_o(gfxA), .busy_o(busyA),
    .line_done_o(ldA), .frame_done_o(fdA)
  );

  // Instance B: 32-wide sprite with all ROM bits set, used for 2x scaling.
  logic       vstartB, loadB, hstartB, hmB, vmB, xsB, ysB;
  logic [5:0] romAddrB;
  logic [7:0] romBitsB;
  logic       gfxB, busyB, ldB, fdB;

  assign romBitsB = 8'hFF;

  sprite_renderer_param #(.W(32), .H(16), .ROM_DW(8)) dutB (
    .clk(clk), .reset(reset), .vstart_i(vstartB), .load_i(loadB), .hstart_i(hstartB),
    .hmirror_i(hmB), .vmirror_i(vmB), .xscale_i(xsB), .yscale_i(ysB),
    .rom_addr_o(romAddrB), .rom_bits_i(romBitsB), .gfx_o(gfxB), .busy_o(busyB),
    .line_done_o(ldB), .frame_done_o(fdB)
  );

  // Instance C: minimum 8x2 sprite, one ROM word per row.
  logic       vstartC, loadC, hstartC, hmC, vmC, xsC, ysC;
  logic [0:0] romAddrC;
  logic [7:0] romBitsC;
  logic       gfxC, busyC, ldC, fdC;

  assign romBitsC = romAddrC[0] ? 8'hF0 : 8'h0F;

  sprite_renderer_param #(.W(8), .H(2), .ROM_DW(8)) dutC (
    .clk(clk), .reset(reset), .vstart_i(vstartC), .load_i(loadC), .hstart_i(hstartC),
    .hmirror_i(hmC), .vmirror_i(vmC), .xscale_i(xsC), .yscale_i(ysC),
    .rom_addr_o(romAddrC), .rom_bits_i(romBitsC), .gfx_o(gfxC), .busy_o(busyC),
    .line_done_o(ldC), .frame_done_o(fdC)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic startSpriteA(input logic hm, input logic vm);
    hmA = hm; vmA = vm; xsA = 1'b0; ysA = 1'b0;
    vstartA = 1'b1;
    tick();
    vstartA = 1'b0;
    total++;
    if (busyA !== 1'b1) begin
      bad++;
      $display("[TB] FAIL startA busy: got %b want 1", busyA);
    end
  endtask

  // One full scanline on instance A; optional noisy strobes that must be ignored.
  task automatic doLineA(input int ln, input int expRow, input logic hm, input logic last,
                         input logic noisy);
    logic [15:0] expData, expVec, obsVec, ldVec, fdVec, fdExp;
    logic [4:0]  ea0, ea1;
    expData = 16'h0001 << expRow;
    for (int p = 0; p < 16; p++) expVec[p] = expData[hm ? 15 - p : p];
    ea0   = 5'(expRow * 2);
    ea1   = 5'(expRow * 2 + 1);
    fdExp = last ? 16'h8000 : 16'h0000;
    if (noisy) vstartA = 1'b1;
    loadA = 1'b1;
    tick();
    loadA = 1'b0; vstartA = 1'b0;
    tick();
    total++;
    if (romAddrA !== ea0) begin
      bad++;
      $display("[TB] FAIL addrA word0 line %0d: got %h want %h", ln, romAddrA, ea0);
    end
    if (noisy) hstartA = 1'b1;
    tick();
    hstartA = 1'b0;
    tick();
    total++;
    if (romAddrA !== ea1) begin
      bad++;
      $display("[TB] FAIL addrA word1 line %0d: got %h want %h", ln, romAddrA, ea1);
    end
    tick();
    if (noisy) begin
      repeat (3) tick();
      total++;
      if (gfxA !== 1'b0 || ldA !== 1'b0) begin
        bad++;
        $display("[TB] FAIL earlyHstartA line %0d: gfx=%b ld=%b want 0 0", ln, gfxA, ldA);
      end
    end
    hstartA = 1'b1;
    tick();
    hstartA = 1'b0;
    total++;
    if (gfxA !== 1'b0) begin
      bad++;
      $display("[TB] FAIL gfxA t+1 line %0d: got %b want 0", ln, gfxA);
    end
    for (int k = 0; k < 16; k++) begin
      if (noisy && k == 3) loadA = 1'b1;
      if (k == 6) loadA = 1'b0;
      tick();
      obsVec[k] = gfxA; ldVec[k] = ldA; fdVec[k] = fdA;
    end
    total++;
    if (obsVec !== expVec) begin
      bad++;
      $display("[TB] FAIL pixelsA line %0d: got %h want %h", ln, obsVec, expVec);
    end
    total++;
    if (ldVec !== 16'h8000) begin
      bad++;
      $display("[TB] FAIL lineDoneA line %0d: got %h want 8000", ln, ldVec);
    end
    total++;
    if (fdVec !== fdExp) begin
      bad++;
      $display("[TB] FAIL frameDoneA line %0d: got %h want %h", ln, fdVec, fdExp);
    end
    tick();
    total++;
    if (gfxA !== 1'b0 || ldA !== 1'b0 || busyA !== !last) begin
      bad++;
      $display("[TB] FAIL tailA line %0d: gfx=%b ld=%b busy=%b want 0 0 %b",
               ln, gfxA, ldA, busyA, !last);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({romAddrA, gfxA, busyA, ldA, fdA} !== 9'd0) begin
      bad++;
      $display("[TB] FAIL resetA: got %h want 000", {romAddrA, gfxA, busyA, ldA, fdA});
    end
    total++;
    if ({romAddrB, gfxB, busyB, ldB, fdB, romAddrC, gfxC, busyC, ldC, fdC} !== 15'd0) begin
      bad++;
      $display("[TB] FAIL resetBC: got %h want 0000",
               {romAddrB, gfxB, busyB, ldB, fdB, romAddrC, gfxC, busyC, ldC, fdC});
    end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    startSpriteA(1'b0, 1'b0);
    for (int ln = 0; ln < 16; ln++) doLineA(ln, ln, 1'b0, ln == 15, 1'b0);
  endtask

  task automatic test_mirror;
    startSpriteA(1'b1, 1'b1);
    for (int ln = 0; ln < 16; ln++) begin
      if (ln == 4) begin hmA = 1'b0; vmA = 1'b0; end
      if (ln == 9) hmA = 1'b1;
      doLineA(ln, 15 - ln, 1'b1, ln == 15, 1'b0);
    end
  endtask

  task automatic test_strobe_filter;
    startSpriteA(1'b0, 1'b0);
    for (int ln = 0; ln < 16; ln++) doLineA(ln, ln, 1'b0, ln == 15, ln < 3);
  endtask

  task automatic test_reset_abort;
    startSpriteA(1'b0, 1'b0);
    for (int ln = 0; ln < 5; ln++) doLineA(ln, ln, 1'b0, 1'b0, 1'b0);
    loadA = 1'b1;
    tick();
    loadA = 1'b0;
    repeat (4) tick();
    hstartA = 1'b1;
    tick();
    hstartA = 1'b0;
    repeat (6) tick();
    total++;
    if (gfxA !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pixel5A before reset: got %b want 1", gfxA);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({gfxA, busyA, ldA, fdA} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL asyncResetA: got %b want 0000", {gfxA, busyA, ldA, fdA});
    end
    tick();
    #2 reset = 1'b0;
    tick();
    startSpriteA(1'b0, 1'b0);
    doLineA(0, 0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    tick();
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_scale;
    int ones, ldCount, ldAt, fdCount, fdAt;
    logic [5:0] ea;
    xsB = 1'b1; ysB = 1'b1;
    vstartB = 1'b1;
    tick();
    vstartB = 1'b0;
    for (int ln = 0; ln < 32; ln++) begin
      loadB = 1'b1;
      tick();
      loadB = 1'b0;
      for (int w = 0; w < 4; w++) begin
        tick();
        ea = 6'((ln / 2) * 4 + w);
        total++;
        if (romAddrB !== ea) begin
          bad++;
          $display("[TB] FAIL addrB line %0d word %0d: got %h want %h", ln, w, romAddrB, ea);
        end
        tick();
      end
      hstartB = 1'b1;
      tick();
      hstartB = 1'b0;
      total++;
      if (gfxB !== 1'b0) begin
        bad++;
        $display("[TB] FAIL gfxB t+1 line %0d: got %b want 0", ln, gfxB);
      end
      ones = 0; ldCount = 0; ldAt = -1; fdCount = 0; fdAt = -1;
      for (int c = 0; c < 64; c++) begin
        tick();
        if (gfxB === 1'b1) ones++;
        if (ldB === 1'b1) begin ldCount++; ldAt = c; end
        if (fdB === 1'b1) begin fdCount++; fdAt = c; end
      end
      total++;
      if (ones != 64) begin
        bad++;
        $display("[TB] FAIL onesB line %0d: got %0d want 64", ln, ones);
      end
      total++;
      if (ldCount != 1 || ldAt != 63) begin
        bad++;
        $display("[TB] FAIL lineDoneB line %0d: count=%0d at=%0d want 1 at 63", ln, ldCount, ldAt);
      end
      total++;
      if (fdCount != ((ln == 31) ? 1 : 0) || (ln == 31 && fdAt != 63)) begin
        bad++;
        $display("[TB] FAIL frameDoneB line %0d: count=%0d at=%0d", ln, fdCount, fdAt);
      end
      tick();
      total++;
      if (gfxB !== 1'b0 || busyB !== (ln != 31)) begin
        bad++;
        $display("[TB] FAIL tailB line %0d: gfx=%b busy=%b", ln, gfxB, busyB);
      end
    end
  endtask

  task automatic test_min_size;
    int ldTotal, fdTotal;
    logic [7:0] obs, expRow;
    ldTotal = 0; fdTotal = 0;
    vstartC = 1'b1;
    tick();
    vstartC = 1'b0;
    for (int ln = 0; ln < 2; ln++) begin
      expRow = (ln == 1) ? 8'hF0 : 8'h0F;
      loadC = 1'b1;
      tick();
      loadC = 1'b0;
      tick();
      total++;
      if (romAddrC !== 1'(ln)) begin
        bad++;
        $display("[TB] FAIL addrC line %0d: got %h want %0d", ln, romAddrC, ln);
      end
      tick();
      hstartC = 1'b1;
      tick();
      hstartC = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick();
        obs[k] = gfxC;
        if (ldC === 1'b1) ldTotal++;
        if (fdC === 1'b1) fdTotal++;
      end
      total++;
      if (obs !== expRow) begin
        bad++;
        $display("[TB] FAIL pixelsC line %0d: got %h want %h", ln, obs, expRow);
      end
      tick();
    end
    total++;
    if (ldTotal != 2 || fdTotal != 1 || busyC !== 1'b0) begin
      bad++;
      $display("[TB] FAIL strobesC: ld=%0d fd=%0d busy=%b want 2 1 0", ldTotal, fdTotal, busyC);
    end
  endtask

  initial begin
    reset = 1'b1;
    {vstartA, loadA, hstartA, hmA, vmA, xsA, ysA} = '0;
    {vstartB, loadB, hstartB, hmB, vmB, xsB, ysB} = '0;
    {vstartC, loadC, hstartC, hmC, vmC, xsC, ysC} = '0;
    test_reset();
    test_basic();
    test_mirror();
    test_strobe_filter();
    test_reset_abort();
    test_scale();
    test_min_size();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
